// File: rtl/blake2_core_arbiter.sv
// blake2_core_arbiter
//
// Shares one BLAKE2 hash core between NREQ clients. One block request is
// accepted at a time under round-robin priority. The block is launched into
// the core with a single-cycle valid pulse. The digest, or a watchdog error,
// is returned through a valid/ready response port and tagged with the index
// of the requester.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   req_valid_i    per-requester request valid (NREQ bits)
//   req_data_i     per-requester block; slice i is [i*DW +: DW]
//   req_ready_o    one-hot accept; only asserted in IDLE
//   core_valid_o   single-cycle launch pulse to the core
//   core_data_o    block presented to the core
//   core_hash_v_i  core digest valid
//   core_hash_i    core digest
//   rsp_valid_o    response valid
//   rsp_ready_i    response consumer ready
//   rsp_id_o       requester index that owns the response
//   rsp_hash_o     digest (zero on error)
//   rsp_err_o      watchdog expired before the core answered
module blake2_core_arbiter #(
    parameter int NREQ    = 2,
    parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int DW      = 1024,
    parameter int HW      = 512,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic              core_valid_o,
    output logic [DW-1:0]     core_data_o,
    input  logic              core_hash_v_i,
    input  logic [HW-1:0]     core_hash_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [IDW-1:0]    rsp_id_o,
    output logic [HW-1:0]     rsp_hash_o,
    output logic              rsp_err_o
);

    localparam int CNTW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state;
    logic [IDW-1:0]    last;
    logic [CNTW-1:0]   cnt;

    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_idx;
    logic [DW-1:0]     grant_data;
    logic              found;
    logic [IDW-1:0]    cand;

    // Round-robin search starting one past the last winner, wrapping modulo NREQ.
    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        grant_data = '0;
        found      = 1'b0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last) + k) % NREQ);
            if (!found && state == ST_IDLE && req_valid_i[cand]) begin
                found       = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_data = req_data_i[i*DW +: DW];
            end
        end
    end

    assign req_ready_o = grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            last         <= IDW'(NREQ - 1);
            cnt          <= '0;
            core_valid_o <= 1'b0;
            core_data_o  <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_id_o     <= '0;
            rsp_hash_o   <= '0;
            rsp_err_o    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        core_data_o  <= grant_data;
                        rsp_id_o     <= grant_idx;
                        last         <= grant_idx;
                        core_valid_o <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end
                // Launch pulse is visible for this one cycle only.
                ST_ISSUE: begin
                    core_valid_o <= 1'b0;
                    cnt          <= '0;
                    state        <= ST_WAIT;
                end
                // Hash takes precedence over a watchdog expiry in the same cycle.
                ST_WAIT: begin
                    cnt <= cnt + CNTW'(1);
                    if (core_hash_v_i) begin
                        rsp_hash_o  <= core_hash_i;
                        rsp_err_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= ST_RESP;
                    end else if (cnt == CNTW'(TIMEOUT - 1)) begin
                        rsp_hash_o  <= '0;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blake2_core_arbiter.sv
module tb_blake2_core_arbiter;

    localparam int NREQ    = 2;
    localparam int IDW     = 1;
    localparam int DW      = 128;
    localparam int HW      = 64;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid_i;
    logic [NREQ*DW-1:0] req_data_i;
    logic [NREQ-1:0]   req_ready_o;
    logic              core_valid_o;
    logic [DW-1:0]     core_data_o;
    logic              core_hash_v_i;
    logic [HW-1:0]     core_hash_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [IDW-1:0]    rsp_id_o;
    logic [HW-1:0]     rsp_hash_o;
    logic              rsp_err_o;

    blake2_core_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .DW(DW), .HW(HW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
        .core_valid_o(core_valid_o), .core_data_o(core_data_o),
        .core_hash_v_i(core_hash_v_i), .core_hash_i(core_hash_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_id_o(rsp_id_o), .rsp_hash_o(rsp_hash_o), .rsp_err_o(rsp_err_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]    rv;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        int            lat;     // core answers at launch+lat; 0 = never
        logic [HW-1:0] h;
        int            exp_id;
        logic          exp_err;
        int            stall;   // cycles of rsp_ready_i low after rsp_valid_o rises
        logic          stray;   // spurious hash-valid during ISSUE
    } vec_t;

    localparam logic [HW-1:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        int k;
        int er;
        int early;
        int bad_hold;
        logic [HW-1:0] eh;
        logic [DW-1:0] ed;
        req_valid_i   = v.rv;
        req_data_i    = {v.d1, v.d0};
        rsp_ready_i   = (v.stall == 0);
        core_hash_v_i = 1'b0;
        #1;
        chk("grant", 128'(req_ready_o), 128'(2'b01 << v.exp_id));
        step();
        ed = (v.exp_id == 1) ? v.d1 : v.d0;
        eh = v.exp_err ? '0 : v.h;
        chk("launch_valid", 128'(core_valid_o), 128'(1));
        chk("launch_data", 128'(core_data_o), 128'(ed));
        chk("ready_busy", 128'(req_ready_o), 128'(0));
        core_hash_v_i = v.stray;
        core_hash_i   = v.stray ? JUNK : v.h;
        er    = (v.lat != 0) ? 2 + v.lat : 2 + TIMEOUT;
        early = 0;
        k     = 1;
        while (k < er) begin
            step();
            k++;
            core_hash_v_i = (v.lat != 0) && (k == 1 + v.lat);
            core_hash_i   = v.h;
            if (k == 2) chk("launch_one_cycle", 128'(core_valid_o), 128'(0));
            if (k < er && rsp_valid_o) early++;
        end
        core_hash_v_i = 1'b0;
        chk("no_early_rsp", 128'(early), 128'(0));
        chk("rsp_valid", 128'(rsp_valid_o), 128'(1));
        chk("rsp_id", 128'(rsp_id_o), 128'(v.exp_id));
        chk("rsp_hash", 128'(rsp_hash_o), 128'(eh));
        chk("rsp_err", 128'(rsp_err_o), 128'(v.exp_err));
        if (v.stall > 0) begin
            bad_hold = 0;
            for (int i = 0; i < v.stall; i++) begin
                step();
                if (rsp_valid_o !== 1'b1 || rsp_hash_o !== eh || rsp_err_o !== v.exp_err ||
                    rsp_id_o !== IDW'(v.exp_id) || req_ready_o !== 2'b00 || core_data_o !== ed)
                    bad_hold++;
            end
            chk("stall_hold", 128'(bad_hold), 128'(0));
            rsp_ready_i = 1'b1;
        end
        step();
        chk("rsp_drop", 128'(rsp_valid_o), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int seen;
        // {rv, d0, d1, lat, h, exp_id, exp_err, stall, stray}
        vecs[0] = '{2'b11, 128'hA0A0, 128'hB1B1, 3, 64'h1111, 0, 1'b0, 0, 1'b0};
        vecs[1] = '{2'b11, 128'hA2A2, 128'hB3B3, 5, 64'h2222, 1, 1'b0, 0, 1'b0};
        vecs[2] = '{2'b11, 128'hA4A4, 128'hB5B5, 1, 64'h3333, 0, 1'b0, 0, 1'b0};
        vecs[3] = '{2'b11, 128'hA6A6, 128'hB7B7, 7, 64'h4444, 1, 1'b0, 0, 1'b0};
        vecs[4] = '{2'b01, 128'hCAFE_0000_1234, 128'h0, 12, 64'h5A5A_0F0F, 0, 1'b0, 0, 1'b0};
        vecs[5] = '{2'b10, 128'h0, 128'hBEEF_7777, 2, 64'h6666_1234, 1, 1'b0, 20, 1'b0};
        vecs[6] = '{2'b01, 128'hD00D, 128'h0, 0, 64'h7777, 0, 1'b1, 0, 1'b0};
        vecs[7] = '{2'b10, 128'h0, 128'hE00E, TIMEOUT, 64'h8888, 1, 1'b0, 0, 1'b0};
        vecs[8] = '{2'b01, 128'hF00F, 128'h0, 4, 64'h9999, 0, 1'b0, 0, 1'b1};

        reset         = 1'b1;
        req_valid_i   = '0;
        req_data_i    = '0;
        core_hash_v_i = 1'b0;
        core_hash_i   = '0;
        rsp_ready_i   = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("rst_ready", 128'(req_ready_o), 128'(0));
        chk("rst_core_valid", 128'(core_valid_o), 128'(0));
        chk("rst_core_data", 128'(core_data_o), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid_o), 128'(0));
        chk("rst_rsp_id", 128'(rsp_id_o), 128'(0));
        chk("rst_rsp_hash", 128'(rsp_hash_o), 128'(0));
        chk("rst_rsp_err", 128'(rsp_err_o), 128'(0));

        // Stray core pulse while idle with no requesters
        core_hash_v_i = 1'b1;
        core_hash_i   = JUNK;
        step();
        core_hash_v_i = 1'b0;
        chk("stray_idle_rsp", 128'(rsp_valid_o), 128'(0));
        chk("stray_idle_hash", 128'(rsp_hash_o), 128'(0));
        chk("stray_idle_launch", 128'(core_valid_o), 128'(0));
        step();
        chk("stray_idle_rsp2", 128'(rsp_valid_o), 128'(0));

        for (int i = 0; i < 9; i++) run_txn(vecs[i]);

        // Abort a transaction from requester 0 while in WAIT
        req_valid_i = 2'b01;
        req_data_i  = {128'h0, 128'h5555_AAAA};
        #1;
        chk("abort_grant", 128'(req_ready_o), 128'(2'b01));
        step();
        req_valid_i = 2'b00;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_core_valid", 128'(core_valid_o), 128'(0));
        chk("abort_core_data", 128'(core_data_o), 128'(0));
        chk("abort_rsp_valid", 128'(rsp_valid_o), 128'(0));
        chk("abort_rsp_id", 128'(rsp_id_o), 128'(0));
        chk("abort_rsp_hash", 128'(rsp_hash_o), 128'(0));
        chk("abort_rsp_err", 128'(rsp_err_o), 128'(0));
        core_hash_v_i = 1'b1;
        core_hash_i   = JUNK;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            core_hash_v_i = 1'b0;
            if (rsp_valid_o || rsp_hash_o != '0) seen++;
        end
        chk("abort_late_hash_ignored", 128'(seen), 128'(0));

        // Priority after reset: requester 0 first, then 1 alone, then 0 again
        begin
            vec_t v;
            v = '{2'b11, 128'h1010, 128'h2020, 2, 64'hAB01, 0, 1'b0, 0, 1'b0};
            run_txn(v);
            v = '{2'b10, 128'h3030, 128'h4040, 3, 64'hAB02, 1, 1'b0, 0, 1'b0};
            run_txn(v);
            v = '{2'b11, 128'h5050, 128'h6060, 1, 64'hAB03, 0, 1'b0, 0, 1'b0};
            run_txn(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/blake2_core_arbiter.md
Name: blake2_core_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one BLAKE2 hash core (blake2b_hash512 or blake2s_hash256) between NREQ requesters.
- Accepts one block request at a time and launches the core with a single-cycle valid pulse.
- Waits for the core's hash-valid, guarded by a watchdog, and returns the digest tagged with the requester index through a valid/ready response port.
- Sits between the hash clients and the shared core instance.

Parameters:
NREQ, 2, number of requesters (2..8)
IDW, 1, width of requester index = $clog2(NREQ), minimum 1
DW, 1024, block width driven to the core (512 for the s variant)
HW, 512, digest width from the core (256 for the s variant)
TIMEOUT, 64, maximum cycles spent in WAIT before an error response; must be at least 2

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid_i  in  NREQ  per-requester request valid
req_data_i  in  NREQ*DW  per-requester block; slice i = [i*DW +: DW]
req_ready_o  out  NREQ  one-hot grant/accept, asserted only in IDLE
core_valid_o  out  1  launch pulse to core valid_i
core_data_o  out  DW  block to core d_i
core_hash_v_i  in  1  core hash-valid
core_hash_i  in  HW  core digest
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumer ready
rsp_id_o  out  IDW  index of requester owning the response
rsp_hash_o  out  HW  digest, or 0 on error
rsp_err_o  out  1  watchdog expired, no digest

Behaviour:
- Single clock clk; reset is synchronous, active-high. All state updates on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - req_ready_o, core_valid_o, rsp_valid_o, rsp_err_o = 0.
  - core_data_o, rsp_hash_o, rsp_id_o = 0.
  - wait counter = 0.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
- Reset asserted in any state aborts the operation at once. Any core result that arrives later is ignored because the state is then IDLE.
- States are IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - req_ready_o is combinational and one-hot.
  - The grant goes to the first requester with req_valid_i set, searching last+1, last+2, … modulo NREQ.
  - If no requester is valid, req_ready_o = 0.
  - On accept (valid & ready): latch the slice into core_data_o, latch the index into rsp_id_o, set last = that index, go to ISSUE.
  - Exactly one request is accepted per transaction.
- ISSUE:
  - core_valid_o = 1 for exactly this one cycle (registered output).
  - Clear the counter and go to WAIT.
  - core_data_o stays stable from ISSUE until the next accept.
- WAIT:
  - The counter increments each cycle.
  - If core_hash_v_i = 1: latch core_hash_i into rsp_hash_o, set rsp_err_o = 0, go to RESP.
  - Otherwise, if the counter reaches TIMEOUT-1: set rsp_hash_o = 0, set rsp_err_o = 1, go to RESP.
  - If hash-valid and timeout happen in the same cycle, the hash wins.
- RESP:
  - rsp_valid_o = 1; rsp_id_o, rsp_hash_o and rsp_err_o are held stable.
  - On rsp_valid_o & rsp_ready_i: go to IDLE and drop rsp_valid_o the next cycle.
  - rsp_ready_i held low stalls RESP indefinitely; there is no watchdog in RESP.
- core_hash_v_i outside WAIT is ignored, including a stray pulse during ISSUE.
- Latency, with accept at cycle T and the core asserting hash-valid at T+1+L (L ≥ 1):
  - core_valid_o is high in cycle T+1.
  - rsp_valid_o is first high in cycle T+2+L.
  - If rsp_ready_i is held high, the earliest next accept is at T+3+L.
- Throughput: one transaction in flight; no pipelining of core requests.
- Requesters must hold req_valid_i and req_data_i stable until accepted. The arbiter does not latch data from requesters that are not granted.

Test Plan:
- Single request: reset, then req_valid_i = 2'b01 with data A; the core model answers 12 cycles after its valid with digest H. Expect req_ready_o = 01 for one cycle, core_valid_o high for exactly one cycle with core_data_o = A, rsp_valid_o with rsp_id_o = 0, rsp_hash_o = H, rsp_err_o = 0, at accept+14.
- Fairness: both requesters valid continuously for 4 transactions. Expect grant order 0,1,0,1, each response tagged with the matching id and digest.
- Back-pressure: rsp_ready_i = 0 for 20 cycles after rsp_valid_o rises. Expect outputs held constant, req_ready_o = 0 throughout, and a new accept only after the handshake.
- Watchdog: the core never responds, TIMEOUT = 64. Expect rsp_valid_o with rsp_err_o = 1 and rsp_hash_o = 0 exactly 64 cycles after entering WAIT. A core_hash_v_i pulse on the same cycle as expiry gives rsp_err_o = 0 with the digest.
- Reset mid-WAIT: assert reset for 1 cycle in WAIT, then the core asserts hash-valid. Expect all outputs 0 and no rsp_valid_o. The next request from requester 1 alone is granted, and with both valid requester 0 is granted first.
- Stray core pulse: core_hash_v_i asserted in IDLE and in ISSUE. Expect no state change or response, and the subsequent real result is returned normally.
